// File: rtl/user_io_pkg.sv
// Shared constants for the MiST user_io SPI channel: command codes, event types,
// FSM encoding and the command decoder used by user_io_mc.
package user_io_pkg;

  localparam logic [7:0] CMD_CORE_ID   = 8'h00;
  localparam logic [7:0] CMD_MOUSE_BTN = 8'h01;
  localparam logic [7:0] CMD_MOUSE     = 8'h04;
  localparam logic [7:0] CMD_KBD       = 8'h05;
  localparam logic [7:0] CMD_STATUS    = 8'h0F;
  localparam logic [7:0] CMD_JOY_BASE  = 8'h10;

  localparam logic [1:0] EVT_MOUSE_X = 2'd0;
  localparam logic [1:0] EVT_MOUSE_Y = 2'd1;
  localparam logic [1:0] EVT_KBD     = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CMD    = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_IGNORE = 2'd3;

  typedef enum logic [2:0] {
    OP_CORE_ID,
    OP_MOUSE_BTN,
    OP_MOUSE,
    OP_KBD,
    OP_STATUS,
    OP_JOY,
    OP_NONE
  } op_e;

  // Joystick codes only exist for channels the core actually has.
  function automatic op_e decode_cmd(input logic [7:0] cmd, input int joy_num);
    op_e op;
    int  c;
    op = OP_NONE;
    c  = int'({24'd0, cmd});
    case (cmd)
      CMD_CORE_ID:   op = OP_CORE_ID;
      CMD_MOUSE_BTN: op = OP_MOUSE_BTN;
      CMD_MOUSE:     op = OP_MOUSE;
      CMD_KBD:       op = OP_KBD;
      CMD_STATUS:    op = OP_STATUS;
      default: begin
        if (c >= int'({24'd0, CMD_JOY_BASE}) && (c - int'({24'd0, CMD_JOY_BASE})) < joy_num)
          op = OP_JOY;
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/user_io_fifo.sv
// Synchronous event FIFO of {type, data} entries. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; no push-to-pop bypass.
module user_io_fifo
  import user_io_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     _rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/user_io_mc.sv
// MiST user_io SPI command decoder, oversampled on the core clock: joysticks,
// mouse buttons and a buffered keyboard/mouse event stream for minimig.
module user_io_mc
  import user_io_pkg::*;
#(
  parameter int         JOY_NUM     = 4,
  parameter int         JOY_W       = 8,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] CORE_ID     = 8'ha1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     _rst,
  input  logic                     spi_sck,
  input  logic                     spi_ss_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic [JOY_NUM*JOY_W-1:0] joy,
  output logic [2:0]               mouse_btn,
  output logic                     evt_valid,
  output logic [7:0]               evt_data,
  output logic [1:0]               evt_type,
  input  logic                     evt_ready,
  output logic                     evt_strobe,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int JB = JOY_W / 8;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_s, ss_s, mosi_s;
  logic sck_d, ss_d, ss_armed;
  logic sck_rise, sck_fall, ss_fall, ss_rise;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte;
  logic       byte_done;

  logic [1:0]  state;
  op_e         cmd_op;
  op_e         op_dec;
  logic [2:0]  joy_sel;
  logic        data_first;
  logic        mouse_y;
  logic [JOY_W-1:0] joy_acc;
  logic [JOY_W-1:0] joy_next;
  logic [1:0]  joy_cnt;
  logic [JOY_NUM-1:0][JOY_W-1:0] joy_r;
  logic [7:0]  tx_sr;

  logic        push;
  logic [9:0]  push_data;
  logic [9:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        drop, status_clear;

  // Synchronisers carry no reset so a reset mid-transfer cannot fake an ss edge.
  always_ff @(posedge clk) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // ss_armed waits for a deasserted select, so a transfer cut by reset stays ignored.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      sck_d    <= 1'b0;
      ss_d     <= 1'b1;
      ss_armed <= 1'b0;
    end else begin
      sck_d <= sck_s;
      ss_d  <= ss_s;
      if (ss_s) ss_armed <= 1'b1;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ss_armed & ss_d & ~ss_s;
  assign ss_rise  = ss_s & ~ss_d;

  always_ff @(posedge clk) begin
    if (!_rst) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss_fall || ss_rise) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (sck_rise && state != ST_IDLE) begin
        rx_sr   <= {rx_sr[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_byte   <= {rx_sr, mosi_s};
        end
      end
    end
  end

  assign op_dec   = decode_cmd(rx_byte, JOY_NUM);
  assign joy_next = JOY_W'({joy_acc, rx_byte});

  assign push = byte_done && !ss_rise && state == ST_DATA &&
                (cmd_op == OP_MOUSE || cmd_op == OP_KBD);
  assign push_data = {(cmd_op == OP_KBD) ? EVT_KBD : (mouse_y ? EVT_MOUSE_Y : EVT_MOUSE_X),
                      rx_byte};
  assign status_clear = byte_done && !ss_rise && state == ST_DATA &&
                        cmd_op == OP_STATUS && data_first;

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state       <= ST_IDLE;
      cmd_op      <= OP_NONE;
      joy_sel     <= '0;
      data_first  <= 1'b0;
      mouse_y     <= 1'b0;
      joy_acc     <= '0;
      joy_cnt     <= '0;
      joy_r       <= '0;
      mouse_btn   <= '0;
      tx_sr       <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= ss_armed & ~ss_s;
      if (ss_rise) begin
        state    <= ST_IDLE;
        joy_acc  <= '0;
        joy_cnt  <= '0;
        tx_sr    <= '0;
        spi_miso <= 1'b0;
      end else if (ss_fall) begin
        state    <= ST_CMD;
        tx_sr    <= '0;
        spi_miso <= 1'b0;
        mouse_y  <= 1'b0;
        joy_acc  <= '0;
        joy_cnt  <= '0;
      end else begin
        if (sck_fall && state != ST_IDLE) begin
          spi_miso <= tx_sr[7];
          tx_sr    <= {tx_sr[6:0], 1'b0};
        end
        if (byte_done) begin
          case (state)
            ST_CMD: begin
              cmd_op     <= op_dec;
              joy_sel    <= rx_byte[2:0];
              data_first <= 1'b1;
              state      <= (op_dec == OP_NONE) ? ST_IGNORE : ST_DATA;
              if (op_dec == OP_CORE_ID) tx_sr <= CORE_ID;
              else if (op_dec == OP_STATUS) tx_sr <= {overflow, 7'(fifo_count)};
            end
            ST_DATA: begin
              data_first <= 1'b0;
              case (cmd_op)
                OP_MOUSE_BTN: mouse_btn <= rx_byte[2:0];
                OP_MOUSE:     mouse_y   <= ~mouse_y;
                OP_JOY: begin
                  // The word only becomes visible once its last byte lands.
                  if (joy_cnt == 2'(JB - 1)) begin
                    for (int n = 0; n < JOY_NUM; n++)
                      if (3'(n) == joy_sel) joy_r[n] <= joy_next;
                    joy_acc <= '0;
                    joy_cnt <= '0;
                  end else begin
                    joy_acc <= joy_next;
                    joy_cnt <= joy_cnt + 2'd1;
                  end
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign joy       = joy_r;
  assign dbg_state = state;

  // evt_valid/evt_ready: an entry is consumed on every cycle where both are high;
  // evt_data/evt_type are stable while evt_valid is high and read as zero otherwise.
  assign evt_valid  = ~fifo_empty;
  assign evt_strobe = evt_valid & evt_ready;
  assign {evt_type, evt_data} = fifo_empty ? 10'd0 : fifo_head;
  assign drop = push & fifo_full & ~evt_strobe;

  always_ff @(posedge clk) begin
    if (!_rst)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (status_clear) overflow <= 1'b0;
  end

  user_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk       (clk),
    ._rst      (_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_strobe),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_user_io_mc.sv
// Directed bench for user_io_mc: SPI master driver, event scoreboard queue and a
// per-cycle compare of joystick/mouse-button words against a behavioural model.
module tb_user_io_mc;
  import user_io_pkg::*;

  localparam int JOY_NUM = 4;
  localparam int JOY_W   = 16;
  localparam int DEPTH   = 8;
  localparam int WINDOW  = 1400;

  logic clk = 1'b0;
  logic _rst = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_ss_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic evt_ready = 1'b0;
  logic spi_miso, spi_miso_oe, evt_valid, evt_strobe, overflow;
  logic [JOY_NUM*JOY_W-1:0] joy;
  logic [2:0] mouse_btn;
  logic [7:0] evt_data;
  logic [1:0] evt_type, dbg_state;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  bit chk_en = 1'b0;
  logic [9:0] exp_q[$];
  logic [JOY_W-1:0] joy_exp [JOY_NUM];
  logic [JOY_W-1:0] joy_old [JOY_NUM];
  longint joy_t = 0;
  logic [2:0] mb_exp = '0;
  logic [2:0] mb_old = '0;
  longint mb_t = 0;
  logic ov_exp = 1'b0;
  logic [7:0] rx_last;

  user_io_mc #(
    .JOY_NUM(JOY_NUM), .JOY_W(JOY_W), .FIFO_DEPTH(DEPTH),
    .CORE_ID(8'hA1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), ._rst(_rst), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .joy(joy), .mouse_btn(mouse_btn), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_type(evt_type), .evt_ready(evt_ready), .evt_strobe(evt_strobe),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk_ok(input string name, input bit ok, input logic [63:0] act,
                        input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_ok(name, act === exp, act, exp);
  endtask

  // driver tasks
  task automatic half();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi_mosi = tx[i];
      half();
      rx_last[i] = spi_miso;
      spi_sck = 1'b1;
      half();
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    rx_last = '0;
    spi_bits(tx, 7, 0);
  endtask

  task automatic spi_start();
    spi_ss_n = 1'b0;
    half();
  endtask

  task automatic spi_end();
    half();
    spi_ss_n = 1'b1;
    half();
    half();
  endtask

  // model updates
  task automatic model_push(input logic [1:0] t, input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back({t, d});
    else ov_exp = 1'b1;
  endtask

  task automatic model_joy(input int n, input logic [JOY_W-1:0] w);
    for (int k = 0; k < JOY_NUM; k++) joy_old[k] = joy_exp[k];
    joy_exp[n] = w;
    joy_t = longint'($time);
  endtask

  task automatic drain(input int expect_n);
    strobe_cnt = 0;
    evt_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    evt_ready = 1'b0;
    chk_ok("drain_done", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    chk("drain_strobes", 64'(strobe_cnt), 64'(expect_n));
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(evt_valid), 64'd0);
  endtask

  // scoreboard / per-cycle compare
  initial begin
    logic [9:0] e;
    logic [JOY_W-1:0] jw;
    bit in_win;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        in_win = (longint'($time) - joy_t) < WINDOW;
        for (int n = 0; n < JOY_NUM; n++) begin
          jw = joy[n*JOY_W +: JOY_W];
          chk_ok("joy_word", (jw === joy_exp[n]) || (in_win && jw === joy_old[n]),
                 64'(jw), 64'(joy_exp[n]));
        end
        in_win = (longint'($time) - mb_t) < WINDOW;
        chk_ok("mouse_btn", (mouse_btn === mb_exp) || (in_win && mouse_btn === mb_old),
               64'(mouse_btn), 64'(mb_exp));
        if (evt_strobe) begin
          if (exp_q.size() == 0) begin
            chk("evt_unexpected", 64'(evt_strobe), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("evt_entry", 64'({evt_type, evt_data}), 64'(e));
            strobe_cnt++;
          end
        end
      end
    end
  end

  // directed sequence
  initial begin
    for (int n = 0; n < JOY_NUM; n++) begin
      joy_exp[n] = '0;
      joy_old[n] = '0;
    end
    repeat (5) @(posedge clk);
    #1;
    _rst = 1'b1;
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_evt_head", 64'({evt_type, evt_data}), 64'd0);
    chk("rst_strobe", 64'(evt_strobe), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_joy", 64'(joy), 64'd0);
    chk("rst_mouse_btn", 64'(mouse_btn), 64'd0);
    chk("rst_miso", 64'({spi_miso, spi_miso_oe}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk_en = 1'b1;

    // core id
    spi_start();
    chk("oe_during_ss", 64'(spi_miso_oe), 64'd1);
    spi_byte(8'h00);
    spi_byte(8'h00);
    chk("core_id", 64'(rx_last), 64'hA1);
    spi_end();
    chk("oe_after_ss", 64'(spi_miso_oe), 64'd0);

    // joystick 2, 16-bit word
    spi_start();
    spi_byte(8'h12);
    spi_byte(8'hAB);
    model_joy(2, 16'hABCD);
    spi_byte(8'hCD);
    spi_end();
    chk("joy2_word", 64'(joy[2*JOY_W +: JOY_W]), 64'hABCD);

    // joystick index == JOY_NUM is ignored
    spi_start();
    spi_byte(8'h14);
    chk("ignore_state", 64'(dbg_state), 64'(ST_IGNORE));
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_end();
    chk("joy_untouched", 64'(joy), {16'h0000, 16'hABCD, 16'h0000, 16'h0000});

    // mouse buttons
    spi_start();
    spi_byte(8'h01);
    mb_old = mb_exp;
    mb_exp = 3'd5;
    mb_t = longint'($time);
    spi_byte(8'h05);
    spi_end();
    chk("mouse_btn_lit", 64'(mouse_btn), 64'd5);

    // mouse motion X then Y
    spi_start();
    spi_byte(8'h04);
    model_push(EVT_MOUSE_X, 8'h05);
    spi_byte(8'h05);
    model_push(EVT_MOUSE_Y, 8'hFB);
    spi_byte(8'hFB);
    spi_end();
    chk("mouse_model_len", 64'(exp_q.size()), 64'd2);
    chk("mouse_head", 64'({evt_valid, evt_type, evt_data}), 64'({1'b1, 2'd0, 8'h05}));
    drain(2);

    // overflow: ten key bytes into an eight-entry FIFO
    spi_start();
    spi_byte(8'h05);
    for (int i = 0; i < 10; i++) begin
      model_push(EVT_KBD, 8'h30 + 8'(i));
      spi_byte(8'h30 + 8'(i));
    end
    spi_end();
    chk("ovf_model", 64'(overflow), 64'(ov_exp));
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head", 64'({evt_type, evt_data}), 64'({2'd2, 8'h30}));
    spi_start();
    spi_byte(8'h0F);
    spi_byte(8'h00);
    chk("status_model", 64'(rx_last), 64'({ov_exp, 7'(exp_q.size())}));
    chk("status_lit", 64'(rx_last), 64'h88);
    ov_exp = 1'b0;
    spi_end();
    chk("ovf_cleared", 64'(overflow), 64'd0);
    drain(8);

    // abort after five bits of a joystick byte
    spi_start();
    spi_byte(8'h11);
    spi_byte(8'h12);
    spi_bits(8'h34, 7, 3);
    spi_end();
    chk("abort_joy1", 64'(joy[1*JOY_W +: JOY_W]), 64'h0);
    spi_start();
    spi_byte(8'h11);
    spi_byte(8'h56);
    model_joy(1, 16'h5678);
    spi_byte(8'h78);
    spi_end();
    chk("after_abort_joy1", 64'(joy[1*JOY_W +: JOY_W]), 64'h5678);

    // reset in the middle of a keyboard transfer
    spi_start();
    spi_byte(8'h05);
    for (int i = 0; i < 3; i++) begin
      model_push(EVT_KBD, 8'h61 + 8'(i));
      spi_byte(8'h61 + 8'(i));
    end
    chk("pre_rst_valid", 64'(evt_valid), 64'd1);
    spi_bits(8'h64, 7, 4);
    chk_en = 1'b0;
    _rst = 1'b0;
    @(posedge clk);
    #1;
    _rst = 1'b1;
    exp_q.delete();
    for (int n = 0; n < JOY_NUM; n++) joy_exp[n] = '0;
    mb_exp = '0;
    joy_t = 0;
    mb_t = 0;
    chk("rst2_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst2_joy", 64'(joy), 64'd0);
    chk("rst2_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst2_mouse_btn", 64'(mouse_btn), 64'd0);
    chk_en = 1'b1;
    spi_bits(8'h64, 3, 0);
    spi_byte(8'h65);
    chk("rst2_ignored_state", 64'(dbg_state), 64'(ST_IDLE));
    spi_end();
    chk("rst2_no_events", 64'(evt_valid), 64'd0);

    // normal decode resumes
    spi_start();
    spi_byte(8'h05);
    model_push(EVT_KBD, 8'h42);
    spi_byte(8'h42);
    spi_end();
    chk("post_rst_head", 64'({evt_type, evt_data}), 64'({2'd2, 8'h42}));
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_io_mc.md
Name: user_io_mc

Overview:
Parametrised successor to the single-clock-domain user_io SPI channel. Decodes MiST controller SPI commands into N joystick words of configurable width, a mouse button register, and a buffered keyboard/mouse event stream. Oversamples SPI on the core clock, so there is no SPI clock domain. Sits beside the minimig core; its event FIFO feeds the minimig kbd/mouse interface with a valid/ready handshake.

Parameters:
JOY_NUM, 4, number of joystick channels (1..8)
JOY_W, 8, joystick word width; multiple of 8, 8..32
FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64
CORE_ID, 8'ha1, byte returned by the core-id command
SYNC_STAGES, 2, synchroniser depth for SPI inputs (>=2)

Ports:
clk  in  1  core clock (clk_28 domain); must be >= 4x spi_sck
_rst  in  1  synchronous active-low reset
spi_sck  in  1  SPI clock, asynchronous
spi_ss_n  in  1  SPI select for user_io (CONF_DATA0), active low
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out
spi_miso_oe  out  1  high while spi_ss_n synchronised low
joy  out  JOY_NUM*JOY_W  joystick words; channel n at [n*JOY_W +: JOY_W]
mouse_btn  out  3  mouse buttons
evt_valid  out  1  FIFO head valid
evt_data  out  8  FIFO head data byte
evt_type  out  2  FIFO head type: 0 mouse X, 1 mouse Y, 2 keyboard
evt_ready  in  1  consumer pop
evt_strobe  out  1  evt_valid & evt_ready, one-cycle pulse per pop
overflow  out  1  sticky FIFO-drop flag

Behaviour:
- Reset values: joy=0, mouse_btn=0, FIFO empty, evt_valid=0, evt_data=0, evt_type=0, evt_strobe=0, overflow=0, spi_miso=0, spi_miso_oe=0, FSM=IDLE.
- Synchronisers: sck, ss_n and mosi each pass SYNC_STAGES flops. Edge detect on the synchronised sck. SPI mode 0, MSB first.
- Bit timing: sample MOSI on the sck rising edge. Update MISO on the sck falling edge. A byte completes on the 8th rising edge.
- FSM states: IDLE, CMD, DATA, IGNORE.
  - ss_n falling: go to CMD, clear the bit counter, load MISO shifter with 0, reset the X/Y toggle to X.
  - Completed byte in CMD: decode the command and go to DATA, or go to IGNORE if the command is unknown.
  - ss_n rising in any state: go to IDLE, discard the partial byte and partial joystick word.
- Commands (byte 0):
  - 0x00: core id. MISO shifts CORE_ID during byte 1.
  - 0x01: mouse buttons. Each data byte loads mouse_btn from bits [2:0].
  - 0x04: mouse motion. Data bytes are pushed alternately as type 0 then type 1, starting at X.
  - 0x05: keyboard. Each data byte is pushed as type 2.
  - 0x0F: status. MISO shifts {overflow, FIFO count[6:0]} during byte 1. Completion of byte 1 clears overflow.
  - 0x10+n, n < JOY_NUM: joystick n. Accumulates JOY_W/8 bytes MSB first. joy[n] commits atomically on the last byte, one cycle after its 8th rising edge. Further bytes start a new word.
  - 0x10+n with n >= JOY_NUM, and all other codes: IGNORE until ss_n rises.
- Push latency: the FIFO entry is visible on evt_valid 2 clk after the completing sck edge is detected.
- FIFO rules:
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - A push to a full FIFO without a pop drops the byte and sets overflow. overflow stays set until a status read completes.
  - Pop occurs only when evt_valid & evt_ready. Pop when empty is a no-op.
  - Simultaneous push and pop on an empty FIFO: the push is stored and evt_valid rises next cycle (no bypass).
  - Count saturates nowhere: the width is clog2(FIFO_DEPTH)+1 and pointers wrap modulo FIFO_DEPTH.
- evt_data/evt_type hold the head entry while evt_valid=1 and are don't-care otherwise.
- Reset asserted mid-transfer: immediate return to reset values on the next clk edge, including flushing the FIFO.

Decomposition:
- Package user_io_pkg:
  - command constants CMD_CORE_ID, CMD_MOUSE_BTN, CMD_MOUSE, CMD_KBD, CMD_STATUS, CMD_JOY_BASE
  - event type constants EVT_MOUSE_X, EVT_MOUSE_Y, EVT_KBD
  - FSM state encoding
- One sub-module: user_io_fifo, a synchronous FIFO of 10-bit entries (type + data) with FIFO_DEPTH, full/empty/count outputs and simultaneous-push/pop support.

Test Plan:
- Core id: SS low, send 0x00 then 0x00 -> MISO reads 0xA1 in byte 1; spi_miso_oe high only during SS.
- Joystick: JOY_W=16, send 0x12, 0xAB, 0xCD -> joy[2]=16'hABCD after the last byte, never 16'hAB00 in between. Repeat with n=JOY_NUM -> no joy change.
- Mouse/FIFO: send 0x04, 0x05, 0xFB with evt_ready=0 -> two entries, (type0, 0x05) then (type1, 0xFB). Drain with evt_ready=1 -> two evt_strobe pulses in that order.
- Overflow: FIFO_DEPTH=8, send 0x05 plus 10 key bytes with evt_ready=0 -> 8 entries kept, overflow=1. Then status read -> MISO returns 0x88, overflow clears after the byte.
- Abort: raise SS after 5 bits of a joystick byte -> joy unchanged. The next transaction decodes normally from CMD.
- Reset: assert _rst low for 1 clk mid-keyboard transfer with 3 entries queued -> FIFO empty, joy=0, FSM=IDLE. The remaining bits of that transfer are ignored until the next SS falling edge.
